// File: rtl/seq_divider_if.sv
// Request/response bundle for the sequential divider: operands in, quotient/remainder out.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, WIDTH steps per divide.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned REM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;        // shifting dividend / growing quotient
  logic [REM_W-1:0]   r_q, r_d;        // partial remainder, one guard bit
  logic [WIDTH-1:0]   dvs_q, dvs_d;    // latched divisor
  logic [CNT_W-1:0]   cnt_q, cnt_d;    // restoring step index
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State and datapath registers; reset clears everything, aborting any divide in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, restoring step and result capture
  always_comb begin
    logic [REM_W-1:0] r_shift;
    logic [REM_W-1:0] r_trial;
    logic             fits;

    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    // Shift the next dividend bit into the remainder and try subtracting the divisor
    r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    r_trial = r_shift - {1'b0, dvs_q};
    fits    = (r_shift >= {1'b0, dvs_q});

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_d     = bus.dividend;
          dvs_d   = bus.divisor;
          r_d     = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (bus.divisor == '0) ? FIN : RUN;
        end
      end

      RUN: begin
        busy_d = 1'b1;
        r_d    = fits ? r_trial : r_shift;
        q_d    = {q_q[WIDTH-2:0], fits};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end

      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
        // Zero divisor: saturate quotient and pass the untouched dividend through
        if (dvs_q == '0) begin
          quo_d = '1;
          rem_d = q_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = q_q;
          rem_d = r_q[WIDTH-1:0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
